// File: rtl/type_lookup_pipe_pkg.sv
// Shared widths and record types for the parser's ternary type-lookup stage.
// The module parameters default to these constants so a stage can be resized in one place.
package type_lookup_pkg;

   localparam int DEF_RULE_NUM         = 8;
   localparam int DEF_TYPE_NUM         = 2;
   localparam int DEF_TYPE_WIDTH       = 16;
   localparam int DEF_KEY_FIELD_NUM    = 8;
   localparam int DEF_KEY_OFFSET_WIDTH = 6;
   localparam int DEF_HEAD_SHIFT_WIDTH = 6;
   localparam int DEF_META_SHIFT_WIDTH = 4;
   localparam int DEF_CNT_WIDTH        = 32;
   localparam int DEF_IDX_W            = $clog2(DEF_RULE_NUM + 1);
   localparam int DEF_TYPE_BITS        = DEF_TYPE_NUM * DEF_TYPE_WIDTH;

   typedef struct packed {
      logic                     valid;
      logic [DEF_TYPE_BITS-1:0] data;
      logic [DEF_TYPE_BITS-1:0] mask;
   } type_rule_t;

   typedef struct packed {
      logic [DEF_KEY_FIELD_NUM-1:0][DEF_KEY_OFFSET_WIDTH-1:0] key_offset;
      logic [DEF_HEAD_SHIFT_WIDTH-1:0]                        head_shift;
      logic [DEF_META_SHIFT_WIDTH-1:0]                        meta_shift;
   } type_action_t;

endpackage

// File: rtl/type_lookup_pipe_if.sv
// Lookup request/response channel between the type-field extractor (master)
// and the type lookup pipeline (slave).
interface type_lookup_pipe_if
   import type_lookup_pkg::*;
#(
   parameter int TYPE_NUM         = DEF_TYPE_NUM,
   parameter int TYPE_WIDTH       = DEF_TYPE_WIDTH,
   parameter int KEY_FIELD_NUM    = DEF_KEY_FIELD_NUM,
   parameter int KEY_OFFSET_WIDTH = DEF_KEY_OFFSET_WIDTH,
   parameter int HEAD_SHIFT_WIDTH = DEF_HEAD_SHIFT_WIDTH,
   parameter int META_SHIFT_WIDTH = DEF_META_SHIFT_WIDTH,
   parameter int IDX_W            = DEF_IDX_W
);

   logic                                      i_req_valid;
   logic                                      o_req_ready;
   logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_req_type;
   logic                                      o_rsp_valid;
   logic                                      i_rsp_ready;
   logic                                      o_rsp_hit;
   logic [IDX_W-1:0]                          o_rsp_rule_idx;
   logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0] o_rsp_key_offset;
   logic [HEAD_SHIFT_WIDTH-1:0]               o_rsp_head_shift;
   logic [META_SHIFT_WIDTH-1:0]               o_rsp_meta_shift;

   modport master (
      output i_req_valid, i_req_type, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_rule_idx,
             o_rsp_key_offset, o_rsp_head_shift, o_rsp_meta_shift
   );

   modport slave (
      input  i_req_valid, i_req_type, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_rule_idx,
             o_rsp_key_offset, o_rsp_head_shift, o_rsp_meta_shift
   );

endinterface

// File: rtl/type_lookup_pipe_prio_hit_encoder.sv
// Lowest-index priority encoder over the rule hit vector; reports RULE_NUM when
// nothing hit so the miss index falls out without extra logic.
module prio_hit_encoder #(
   parameter int RULE_NUM = 8,
   parameter int IDX_W    = $clog2(RULE_NUM + 1)
) (
   input  logic [RULE_NUM-1:0] i_hit_vec,
   output logic [IDX_W-1:0]    o_idx,
   output logic                o_any_hit
);

   // Scan from the top so the last overwrite is the lowest set index
   always_comb begin
      o_idx     = IDX_W'(RULE_NUM);
      o_any_hit = |i_hit_vec;
      for (int i = RULE_NUM - 1; i >= 0; i--) begin
         o_idx = i_hit_vec[i] ? IDX_W'(i) : o_idx;
      end
   end

endmodule

// File: rtl/type_lookup_pipe.sv
// Two-stage ternary type lookup: S1 registers the rule hit vector, S2 registers the
// selected action. Config writes wait for an empty pipeline; per-rule hit counters.
module type_lookup_pipe
   import type_lookup_pkg::*;
#(
   parameter int RULE_NUM         = DEF_RULE_NUM,
   parameter int TYPE_NUM         = DEF_TYPE_NUM,
   parameter int TYPE_WIDTH       = DEF_TYPE_WIDTH,
   parameter int KEY_FIELD_NUM    = DEF_KEY_FIELD_NUM,
   parameter int KEY_OFFSET_WIDTH = DEF_KEY_OFFSET_WIDTH,
   parameter int HEAD_SHIFT_WIDTH = DEF_HEAD_SHIFT_WIDTH,
   parameter int META_SHIFT_WIDTH = DEF_META_SHIFT_WIDTH,
   parameter int PRIORITY_MODE    = 1,
   parameter int CNT_WIDTH        = DEF_CNT_WIDTH,
   parameter int IDX_W            = $clog2(RULE_NUM + 1)
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   type_lookup_pipe_if.slave                         lk,
   input  logic                                      i_cfg_wr,
   output logic                                      o_cfg_ready,
   input  logic [IDX_W-1:0]                          i_cfg_addr,
   input  logic                                      i_cfg_rule_valid,
   input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_cfg_type_data,
   input  logic [TYPE_NUM*TYPE_WIDTH-1:0]            i_cfg_type_mask,
   input  logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0] i_cfg_key_offset,
   input  logic [HEAD_SHIFT_WIDTH-1:0]               i_cfg_head_shift,
   input  logic [META_SHIFT_WIDTH-1:0]               i_cfg_meta_shift,
   input  logic                                      i_cnt_clr,
   input  logic [IDX_W-1:0]                          i_cnt_rd_addr,
   output logic [CNT_WIDTH-1:0]                      o_cnt_rd_data
);

   localparam int TB = TYPE_NUM * TYPE_WIDTH;
   localparam int KB = KEY_FIELD_NUM * KEY_OFFSET_WIDTH;
   localparam int AB = KB + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   typedef struct packed {
      logic          valid;
      logic [TB-1:0] data;
      logic [TB-1:0] mask;
   } rule_t;

   typedef struct packed {
      logic [KB-1:0]               key_offset;
      logic [HEAD_SHIFT_WIDTH-1:0] head_shift;
      logic [META_SHIFT_WIDTH-1:0] meta_shift;
   } action_t;

   // Entry RULE_NUM of the action table is the programmable miss action
   rule_t                rule_r   [RULE_NUM];
   action_t              action_r [RULE_NUM+1];
   logic [CNT_WIDTH-1:0] cnt_r    [RULE_NUM+1];

   logic                 s1_valid_r;
   logic [RULE_NUM-1:0]  s1_hit_r;
   logic                 s2_valid_r;
   logic                 rsp_hit_r;
   logic [IDX_W-1:0]     rsp_idx_r;
   action_t              rsp_action_r;
   logic [CNT_WIDTH-1:0] cnt_rd_r;

   logic                 s2_adv_s;
   logic                 s1_adv_s;
   logic                 req_ready_s;
   logic                 req_fire_s;
   logic                 rsp_fire_s;
   logic                 cfg_ready_s;
   logic                 cfg_fire_s;
   logic [RULE_NUM-1:0]  hit_vec_s;
   logic [IDX_W-1:0]     first_idx_s;
   logic                 any_hit_s;
   logic [AB-1:0]        or_vec_s;
   action_t              sel_action_s;
   action_t              cfg_action_s;
   logic [CNT_WIDTH-1:0] cnt_rd_s;

   assign s2_adv_s    = !s2_valid_r | lk.i_rsp_ready;
   assign s1_adv_s    = s1_valid_r & s2_adv_s;
   // Holding off requests while a write is pending lets the pipeline drain
   assign req_ready_s = (!s1_valid_r | s2_adv_s) & !i_cfg_wr;
   assign req_fire_s  = lk.i_req_valid & req_ready_s;
   assign rsp_fire_s  = s2_valid_r & lk.i_rsp_ready;
   assign cfg_ready_s = !s1_valid_r & !s2_valid_r;
   assign cfg_fire_s  = i_cfg_wr & cfg_ready_s;

   assign cfg_action_s = '{key_offset: i_cfg_key_offset,
                           head_shift: i_cfg_head_shift,
                           meta_shift: i_cfg_meta_shift};

   // Ternary match of the incoming type fields against every rule
   always_comb begin
      hit_vec_s = '0;
      for (int i = 0; i < RULE_NUM; i++) begin
         hit_vec_s[i] = rule_r[i].valid & ((rule_r[i].mask & lk.i_req_type) == rule_r[i].data);
      end
   end

   // Rule and action table writes, accepted only with the pipeline empty
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < RULE_NUM; i++) begin
            rule_r[i] <= '0;
         end
         for (int i = 0; i <= RULE_NUM; i++) begin
            action_r[i] <= '0;
         end
      end else if (cfg_fire_s) begin
         for (int i = 0; i < RULE_NUM; i++) begin
            if (i_cfg_addr == IDX_W'(i)) begin
               rule_r[i] <= '{valid: i_cfg_rule_valid, data: i_cfg_type_data, mask: i_cfg_type_mask};
            end
         end
         for (int i = 0; i <= RULE_NUM; i++) begin
            if (i_cfg_addr == IDX_W'(i)) begin
               action_r[i] <= cfg_action_s;
            end
         end
      end
   end

   // S1: capture the hit vector on request handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_r <= 1'b0;
         s1_hit_r   <= '0;
      end else if (!s1_valid_r | s2_adv_s) begin
         s1_valid_r <= req_fire_s;
         if (req_fire_s) begin
            s1_hit_r <= hit_vec_s;
         end
      end
   end

   prio_hit_encoder #(
      .RULE_NUM (RULE_NUM),
      .IDX_W    (IDX_W)
   ) u_prio (
      .i_hit_vec (s1_hit_r),
      .o_idx     (first_idx_s),
      .o_any_hit (any_hit_s)
   );

   // Legacy merge: union of every hit rule's action bits
   always_comb begin
      or_vec_s = {AB{1'b0}};
      for (int i = 0; i < RULE_NUM; i++) begin
         or_vec_s = or_vec_s | (s1_hit_r[i] ? AB'(action_r[i]) : {AB{1'b0}});
      end
   end

   // Pick the S2 action: miss entry, winning rule, or merged actions
   always_comb begin
      sel_action_s = action_r[RULE_NUM];
      if (!any_hit_s) begin
         sel_action_s = action_r[RULE_NUM];
      end else if (PRIORITY_MODE != 0) begin
         sel_action_s = action_r[first_idx_s];
      end else begin
         sel_action_s = action_t'(or_vec_s);
      end
   end

   // S2: register the response; data only moves when a new lookup lands
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid_r   <= 1'b0;
         rsp_hit_r    <= 1'b0;
         rsp_idx_r    <= '0;
         rsp_action_r <= '0;
      end else if (s2_adv_s) begin
         s2_valid_r <= s1_adv_s;
         if (s1_valid_r) begin
            rsp_hit_r    <= any_hit_s;
            rsp_idx_r    <= first_idx_s;
            rsp_action_r <= sel_action_s;
         end
      end
   end

   // Saturating hit counters; clear takes precedence over a same-cycle increment
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i <= RULE_NUM; i++) begin
            cnt_r[i] <= '0;
         end
      end else if (i_cnt_clr) begin
         for (int i = 0; i <= RULE_NUM; i++) begin
            cnt_r[i] <= '0;
         end
      end else if (rsp_fire_s) begin
         for (int i = 0; i <= RULE_NUM; i++) begin
            if ((rsp_idx_r == IDX_W'(i)) && (cnt_r[i] != CNT_MAX)) begin
               cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   // Counter read mux; unmatched addresses fall through to zero
   always_comb begin
      cnt_rd_s = '0;
      for (int i = 0; i <= RULE_NUM; i++) begin
         cnt_rd_s = (i_cnt_rd_addr == IDX_W'(i)) ? cnt_r[i] : cnt_rd_s;
      end
   end

   // Registered counter read port
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_rd_r <= '0;
      end else begin
         cnt_rd_r <= cnt_rd_s;
      end
   end

   assign lk.o_req_ready      = req_ready_s;
   assign lk.o_rsp_valid      = s2_valid_r;
   assign lk.o_rsp_hit        = rsp_hit_r;
   assign lk.o_rsp_rule_idx   = rsp_idx_r;
   assign lk.o_rsp_key_offset = rsp_action_r.key_offset;
   assign lk.o_rsp_head_shift = rsp_action_r.head_shift;
   assign lk.o_rsp_meta_shift = rsp_action_r.meta_shift;
   assign o_cfg_ready         = cfg_ready_s;
   assign o_cnt_rd_data       = cnt_rd_r;

endmodule

// File: tb/tb_type_lookup_pipe.sv
// Bench for type_lookup_pipe: a priority-mode and an OR-mode instance share stimulus
// and are compared against a table-level reference model with a 2-slot pipeline queue.
module tb_type_lookup_pipe;
   import type_lookup_pkg::*;

   localparam int RN = 8;
   localparam int KF = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_type = 32'h0;
   logic        rsp_ready = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [3:0]  cfg_addr = 4'h0;
   logic        cfg_rule_valid = 1'b0;
   logic [31:0] cfg_data = 32'h0;
   logic [31:0] cfg_mask = 32'h0;
   logic [47:0] cfg_ko = 48'h0;
   logic [5:0]  cfg_hs = 6'h0;
   logic [3:0]  cfg_ms = 4'h0;
   logic        cnt_clr = 1'b0;
   logic [3:0]  cnt_rd_addr = 4'h0;
   logic        cfg_ready_p, cfg_ready_o;
   logic [31:0] cnt_rd_p;
   logic [3:0]  cnt_rd_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   type_lookup_pipe_if lk1 ();
   type_lookup_pipe_if lk0 ();

   assign lk1.i_req_valid = req_valid;
   assign lk1.i_req_type  = req_type;
   assign lk1.i_rsp_ready = rsp_ready;
   assign lk0.i_req_valid = req_valid;
   assign lk0.i_req_type  = req_type;
   assign lk0.i_rsp_ready = rsp_ready;

   type_lookup_pipe #(.PRIORITY_MODE(1), .CNT_WIDTH(32)) dut_p (
      .i_clk(clk), .i_rst_n(rst_n), .lk(lk1),
      .i_cfg_wr(cfg_wr), .o_cfg_ready(cfg_ready_p), .i_cfg_addr(cfg_addr),
      .i_cfg_rule_valid(cfg_rule_valid), .i_cfg_type_data(cfg_data), .i_cfg_type_mask(cfg_mask),
      .i_cfg_key_offset(cfg_ko), .i_cfg_head_shift(cfg_hs), .i_cfg_meta_shift(cfg_ms),
      .i_cnt_clr(cnt_clr), .i_cnt_rd_addr(cnt_rd_addr), .o_cnt_rd_data(cnt_rd_p)
   );

   type_lookup_pipe #(.PRIORITY_MODE(0), .CNT_WIDTH(4)) dut_o (
      .i_clk(clk), .i_rst_n(rst_n), .lk(lk0),
      .i_cfg_wr(cfg_wr), .o_cfg_ready(cfg_ready_o), .i_cfg_addr(cfg_addr),
      .i_cfg_rule_valid(cfg_rule_valid), .i_cfg_type_data(cfg_data), .i_cfg_type_mask(cfg_mask),
      .i_cfg_key_offset(cfg_ko), .i_cfg_head_shift(cfg_hs), .i_cfg_meta_shift(cfg_ms),
      .i_cnt_clr(cnt_clr), .i_cnt_rd_addr(cnt_rd_addr), .o_cnt_rd_data(cnt_rd_o)
   );

   // Reference table; entry RN of the action arrays is the miss action
   logic        m_valid [RN];
   logic [31:0] m_data  [RN];
   logic [31:0] m_mask  [RN];
   logic [5:0]  m_ko    [RN+1][KF];
   logic [5:0]  m_hs    [RN+1];
   logic [3:0]  m_ms    [RN+1];
   longint      m_cnt_p [RN+1];
   int          m_cnt_o [RN+1];
   longint      exp_rd_p = 0;
   int          exp_rd_o = 0;

   typedef struct {
      logic        hit;
      logic [3:0]  idx;
      logic [47:0] ko_p, ko_o;
      logic [5:0]  hs_p, hs_o;
      logic [3:0]  ms_p, ms_o;
   } exp_t;

   exp_t q[$];
   logic head_out = 1'b0;
   logic cfg_done = 1'b0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t predict(logic [31:0] t);
      exp_t e;
      int   first;
      first = RN;
      e.ko_o = 48'h0; e.hs_o = 6'h0; e.ms_o = 4'h0;
      for (int r = 0; r < RN; r++) begin
         if (m_valid[r] && ((t & m_mask[r]) == m_data[r])) begin
            if (first == RN) first = r;
            for (int k = 0; k < KF; k++) e.ko_o[k*6 +: 6] = e.ko_o[k*6 +: 6] | m_ko[r][k];
            e.hs_o = e.hs_o | m_hs[r];
            e.ms_o = e.ms_o | m_ms[r];
         end
      end
      e.hit = (first != RN);
      e.idx = 4'(first);
      for (int k = 0; k < KF; k++) e.ko_p[k*6 +: 6] = m_ko[first][k];
      e.hs_p = m_hs[first];
      e.ms_p = m_ms[first];
      if (first == RN) begin
         e.ko_o = e.ko_p; e.hs_o = e.hs_p; e.ms_o = e.ms_p;
      end
      return e;
   endfunction

   // One clock: check everything observable, then advance the model to the next edge
   task automatic cycle();
      logic exp_ready, rfire, sfire;
      int   a;
      @(negedge clk);
      exp_ready = !cfg_wr && ((q.size() < 2) || rsp_ready);
      chk("req_ready_p", 64'(lk1.o_req_ready), 64'(exp_ready));
      chk("req_ready_o", 64'(lk0.o_req_ready), 64'(exp_ready));
      chk("rsp_valid_p", 64'(lk1.o_rsp_valid), 64'(head_out));
      chk("rsp_valid_o", 64'(lk0.o_rsp_valid), 64'(head_out));
      chk("cfg_ready_p", 64'(cfg_ready_p), 64'(q.size() == 0));
      chk("cfg_ready_o", 64'(cfg_ready_o), 64'(q.size() == 0));
      chk("cnt_rd_p", 64'(cnt_rd_p), 64'(exp_rd_p));
      chk("cnt_rd_o", 64'(cnt_rd_o), 64'(exp_rd_o));
      if (head_out) begin
         chk("hit_p", 64'(lk1.o_rsp_hit), 64'(q[0].hit));
         chk("hit_o", 64'(lk0.o_rsp_hit), 64'(q[0].hit));
         chk("idx_p", 64'(lk1.o_rsp_rule_idx), 64'(q[0].idx));
         chk("idx_o", 64'(lk0.o_rsp_rule_idx), 64'(q[0].idx));
         chk("ko_p", 64'(lk1.o_rsp_key_offset), 64'(q[0].ko_p));
         chk("ko_o", 64'(lk0.o_rsp_key_offset), 64'(q[0].ko_o));
         chk("hs_p", 64'(lk1.o_rsp_head_shift), 64'(q[0].hs_p));
         chk("hs_o", 64'(lk0.o_rsp_head_shift), 64'(q[0].hs_o));
         chk("ms_p", 64'(lk1.o_rsp_meta_shift), 64'(q[0].ms_p));
         chk("ms_o", 64'(lk0.o_rsp_meta_shift), 64'(q[0].ms_o));
      end
      rfire = req_valid && exp_ready;
      sfire = head_out && rsp_ready;
      if (cfg_wr && (q.size() == 0)) begin
         cfg_done = 1'b1;
         a = int'(cfg_addr);
         if (a < RN) begin
            m_valid[a] = cfg_rule_valid; m_data[a] = cfg_data; m_mask[a] = cfg_mask;
         end
         if (a <= RN) begin
            for (int k = 0; k < KF; k++) m_ko[a][k] = cfg_ko[k*6 +: 6];
            m_hs[a] = cfg_hs; m_ms[a] = cfg_ms;
         end
      end
      a = int'(cnt_rd_addr);
      exp_rd_p = (a <= RN) ? m_cnt_p[a] : 0;
      exp_rd_o = (a <= RN) ? m_cnt_o[a] : 0;
      if (cnt_clr) begin
         for (int i = 0; i <= RN; i++) begin m_cnt_p[i] = 0; m_cnt_o[i] = 0; end
      end else if (sfire) begin
         a = int'(q[0].idx);
         if (m_cnt_p[a] < 64'hFFFF_FFFF) m_cnt_p[a]++;
         if (m_cnt_o[a] < 15) m_cnt_o[a]++;
      end
      if (sfire) begin
         void'(q.pop_front());
         head_out = 1'b0;
      end
      if (!head_out && (q.size() > 0)) head_out = 1'b1;
      if (rfire) q.push_back(predict(req_type));
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(int addr, logic v, logic [31:0] d, logic [31:0] m,
                            logic [47:0] ko, logic [5:0] hs, logic [3:0] ms);
      cfg_addr = 4'(addr); cfg_rule_valid = v; cfg_data = d; cfg_mask = m;
      cfg_ko = ko; cfg_hs = hs; cfg_ms = ms;
      cfg_wr = 1'b1; rsp_ready = 1'b1; cfg_done = 1'b0;
      for (int n = 0; n < 20 && !cfg_done; n++) cycle();
      chk("cfg_handshake", 64'(cfg_done), 64'd1);
      cfg_wr = 1'b0;
   endtask

   task automatic lookup(logic [31:0] t);
      req_type = t; req_valid = 1'b1;
      cycle();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      req_valid = 1'b0; rsp_ready = 1'b1;
      for (int n = 0; n < 20 && q.size() > 0; n++) cycle();
      chk("drain_empty", 64'(q.size()), 64'd0);
      cycle();
   endtask

   initial begin
      for (int i = 0; i < RN; i++) begin m_valid[i] = 1'b0; m_data[i] = 32'h0; m_mask[i] = 32'h0; end
      for (int i = 0; i <= RN; i++) begin
         for (int k = 0; k < KF; k++) m_ko[i][k] = 6'h0;
         m_hs[i] = 6'h0; m_ms[i] = 4'h0; m_cnt_p[i] = 0; m_cnt_o[i] = 0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 64'(lk1.o_rsp_valid), 64'd0);
      chk("rst_rsp_hit", 64'(lk1.o_rsp_hit), 64'd0);
      chk("rst_rsp_idx", 64'(lk0.o_rsp_rule_idx), 64'd0);
      chk("rst_rsp_ko", 64'(lk1.o_rsp_key_offset), 64'd0);
      chk("rst_rsp_hs", 64'(lk0.o_rsp_head_shift), 64'd0);
      chk("rst_cnt_rd", 64'(cnt_rd_p), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cycle();

      // Basic hit on field 1 with head shift 14, checked 2 cycles after acceptance
      cfg_write(0, 1'b1, 32'h0800_0000, 32'hFFFF_0000, 48'h0000_0000_0041, 6'd14, 4'h1);
      rsp_ready = 1'b1;
      lookup(32'h0800_1234);
      cycle();
      chk("basic_hit", 64'(lk1.o_rsp_hit), 64'd1);
      chk("basic_hs", 64'(lk1.o_rsp_head_shift), 64'd14);
      cycle();

      // Rules 1 and 3 both hit: priority picks 1, OR mode merges
      cfg_write(1, 1'b1, 32'h0000_0006, 32'h0000_00FF, 48'h0000_0000_0C03, 6'h05, 4'h2);
      cfg_write(3, 1'b1, 32'h0000_0000, 32'h0000_0F00, 48'h0000_0003_0030, 6'h22, 4'h8);
      lookup(32'h0000_0006);
      cycle();
      chk("multi_idx", 64'(lk0.o_rsp_rule_idx), 64'd1);
      chk("multi_or_hs", 64'(lk0.o_rsp_head_shift), 64'h27);
      cycle();

      // Miss picks up the programmed default action
      cfg_write(RN, 1'b0, 32'h0, 32'h0, 48'h0000_0000_0005, 6'h03, 4'h4);
      lookup(32'hFFFF_FFFF);
      cycle();
      chk("miss_idx", 64'(lk1.o_rsp_rule_idx), 64'd8);
      chk("miss_ko0", 64'(lk1.o_rsp_key_offset[5:0]), 64'd5);
      cycle();

      // Back-to-back with 3 stalled cycles on the response side
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) rsp_ready = 1'b1;
         req_valid = 1'b1;
         req_type = (i % 2 == 0) ? 32'h0800_0000 : 32'h1234_0006;
         cycle();
      end
      drain();

      // Write with two lookups in flight, then a lookup right after the write
      rsp_ready = 1'b0;
      lookup(32'h0000_1234);
      lookup(32'h0800_0000);
      cfg_addr = 4'd2; cfg_rule_valid = 1'b1; cfg_data = 32'h0000_1234; cfg_mask = 32'h0000_FFFF;
      cfg_ko = 48'h0000_0000_0777; cfg_hs = 6'h09; cfg_ms = 4'h6; cfg_wr = 1'b1;
      cycle();
      cycle();
      cfg_write(2, 1'b1, 32'h0000_1234, 32'h0000_FFFF, 48'h0000_0000_0777, 6'h09, 4'h6);
      lookup(32'h0000_1234);
      cycle();
      chk("post_cfg_idx", 64'(lk1.o_rsp_rule_idx), 64'd2);
      drain();

      // Saturation of the 4-bit counter and clear-wins on a coincident hit
      cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
      req_valid = 1'b1; req_type = 32'h0800_1234;
      repeat (20) cycle();
      drain();
      cnt_rd_addr = 4'd0; cycle(); cycle();
      chk("sat_o", 64'(cnt_rd_o), 64'hF);
      chk("count_p", 64'(cnt_rd_p), 64'd20);
      rsp_ready = 1'b0;
      lookup(32'h0800_1234);
      cycle();
      rsp_ready = 1'b1; cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
      cycle(); cycle();
      chk("clr_wins", 64'(cnt_rd_p), 64'd0);

      // Randomized traffic, config writes, clears and counter reads
      for (int n = 0; n < 1500; n++) begin
         int r;
         if ($urandom_range(0, 39) == 0) begin
            logic [31:0] mk;
            mk = $urandom;
            cfg_write($urandom_range(0, 10), ($urandom_range(0, 5) != 0), mk & $urandom,
                      mk, {$urandom, $urandom}, 6'($urandom), 4'($urandom));
         end
         r = $urandom_range(0, RN - 1);
         req_valid = ($urandom_range(0, 3) != 0);
         req_type = ($urandom_range(0, 1) == 1) ? ((m_data[r] & m_mask[r]) | ($urandom & ~m_mask[r]))
                                                : $urandom;
         rsp_ready = ($urandom_range(0, 3) != 0);
         cnt_clr = ($urandom_range(0, 99) == 0);
         cnt_rd_addr = 4'($urandom_range(0, 15));
         cycle();
         cnt_clr = 1'b0;
      end
      drain();
      for (int a = 0; a < 16; a++) begin
         cnt_rd_addr = 4'(a);
         cycle();
      end
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
